ysyx_210247_mem_stage_ctrl: RTL

Consumer end of the exe→mem valid/allow handshake. Drives `mem_allow_in` back to the exe/mem pipeline register and accepts its decoded outputs. Runs one data-memory transaction per load/store over a valid/ready request and response channel. Holds the mem→wb result register and presents it to writeback with the same valid/allow protocol.

---
 rtl/ysyx_210247_mem_stage_ctrl_if.sv | 44 ++++
 rtl/ysyx_210247_mem_stage_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ysyx_210247_mem_stage_ctrl_if.sv
// Bundle of the exe->mem handshake, the data-memory request/response channel
// and the mem->wb result channel. The slave modport is the mem-stage controller's view.
interface ysyx_210247_mem_stage_ctrl_if #(
    parameter int PASS_W = 96,
    parameter int XLEN   = 64
);
    logic                   flush;
    logic                   mem_valid_in;
    logic                   mem_allow_in;
    logic [XLEN-1:0]        mem_alu_res;
    logic [XLEN-1:0]        mem_wdata;
    logic                   mem_ren;
    logic                   mem_wen;
    logic [1:0]             mem_size;
    logic                   mem_unsigned;
    logic [PASS_W-1:0]      mem_pass;
    logic                   req_valid;
    logic                   req_ready;
    logic [XLEN-1:0]        req_addr;
    logic                   req_wen;
    logic [XLEN-1:0]        req_wdata;
    logic [1:0]             req_size;
    logic                   resp_valid;
    logic [XLEN-1:0]        resp_rdata;
    logic                   mem_valid_out;
    logic [PASS_W+XLEN-1:0] mem_to_wb_bus;
    logic                   wb_allow_in;

    modport slave (
        input  flush, mem_valid_in, mem_alu_res, mem_wdata, mem_ren, mem_wen,
               mem_size, mem_unsigned, mem_pass, req_ready, resp_valid,
               resp_rdata, wb_allow_in,
        output mem_allow_in, req_valid, req_addr, req_wen, req_wdata, req_size,
               mem_valid_out, mem_to_wb_bus
    );

    modport master (
        output flush, mem_valid_in, mem_alu_res, mem_wdata, mem_ren, mem_wen,
               mem_size, mem_unsigned, mem_pass, req_ready, resp_valid,
               resp_rdata, wb_allow_in,
        input  mem_allow_in, req_valid, req_addr, req_wen, req_wdata, req_size,
               mem_valid_out, mem_to_wb_bus
    );
endinterface

// File: rtl/ysyx_210247_mem_stage_ctrl.sv
// Memory-stage controller: accepts ops from exe, runs one data-memory transaction
// per load/store and holds the result register presented to writeback.
module ysyx_210247_mem_stage_ctrl #(
    parameter int PASS_W = 96,
    parameter int XLEN   = 64
) (
    input logic                      clk,
    input logic                      rst,
    ysyx_210247_mem_stage_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e                 state_q, state_d;
    logic [XLEN-1:0]        addr_q, addr_d;
    logic [XLEN-1:0]        wdata_q, wdata_d;
    logic                   wen_q, wen_d;
    logic [1:0]             size_q, size_d;
    logic                   unsigned_q, unsigned_d;
    logic [PASS_W-1:0]      pass_q, pass_d;
    logic                   drop_q, drop_d;
    logic                   valid_q, valid_d;
    logic [PASS_W+XLEN-1:0] out_q, out_d;

    logic allow;
    logic accept;
    logic is_mem;

    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] r,
                                                 input logic [1:0]      sz,
                                                 input logic            uns);
        logic s;
        s        = 1'b0;
        load_ext = r;
        case (sz)
            2'd0: begin s = r[7]  & ~uns; load_ext = {{(XLEN-8){s}},  r[7:0]};  end
            2'd1: begin s = r[15] & ~uns; load_ext = {{(XLEN-16){s}}, r[15:0]}; end
            2'd2: begin s = r[31] & ~uns; load_ext = {{(XLEN-32){s}}, r[31:0]}; end
            default: load_ext = r;
        endcase
    endfunction

    // Reset gates the allow so exe sees no acceptance while rst is asserted.
    assign allow  = rst && (state_q == IDLE) && (!valid_q || bus.wb_allow_in);
    assign accept = bus.mem_valid_in && allow && !bus.flush;
    assign is_mem = bus.mem_ren || bus.mem_wen;

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wen_d      = wen_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        pass_d     = pass_q;
        drop_d     = drop_q;
        valid_d    = valid_q;
        out_d      = out_q;

        if (valid_q && bus.wb_allow_in) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    valid_d = 1'b0;
                end else if (accept) begin
                    if (!is_mem) begin
                        valid_d = 1'b1;
                        out_d   = {bus.mem_pass, bus.mem_alu_res};
                    end else begin
                        addr_d     = bus.mem_alu_res;
                        wdata_d    = bus.mem_wdata;
                        wen_d      = bus.mem_wen;
                        size_d     = bus.mem_size;
                        unsigned_d = bus.mem_unsigned;
                        pass_d     = bus.mem_pass;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.flush)     drop_d  = 1'b1;
                if (bus.req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (bus.flush) drop_d = 1'b1;
                if (bus.resp_valid) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    // A flush arriving with the response kills the op just like an earlier one.
                    if (!drop_q && !bus.flush) begin
                        valid_d = 1'b1;
                        out_d   = {pass_q, wen_q ? addr_q : load_ext(bus.resp_rdata, size_q, unsigned_q)};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            pass_q     <= '0;
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wen_q      <= wen_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            pass_q     <= pass_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
        end
    end

    assign bus.mem_allow_in  = allow;
    assign bus.req_valid     = (state_q == REQ);
    assign bus.req_addr      = addr_q;
    assign bus.req_wen       = wen_q;
    assign bus.req_wdata     = wdata_q;
    assign bus.req_size      = size_q;
    assign bus.mem_valid_out = valid_q;
    assign bus.mem_to_wb_bus = out_q;

endmodule
